// File: rtl/alu_sequencer.sv
// Command sequencer that feeds the breadboard ALU from registers, captures its
// result one cycle later, and returns it over a valid/ready handshake.
module alu_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [3:0]       cmd_opcode,
   input  logic [31:0]      cmd_operand,
   output logic [31:0]      alu_input1,
   output logic [31:0]      alu_input2,
   output logic [3:0]       alu_opcode,
   input  logic [63:0]      alu_output1,
   input  logic [1:0]       alu_error,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [63:0]      res_data,
   output logic [1:0]       res_error,
   output logic [31:0]      acc,
   output logic             err_sticky,
   input  logic             err_clear,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [31:0]      in1_q, in1_d;
   logic [31:0]      in2_q, in2_d;
   logic [3:0]       op_q, op_d;
   logic             load_q, load_d;
   logic             res_valid_q, res_valid_d;
   logic [63:0]      res_data_q, res_data_d;
   logic [1:0]       res_error_q, res_error_d;
   logic [31:0]      acc_q, acc_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      state_d     = state_q;
      in1_d       = in1_q;
      in2_d       = in2_q;
      op_d        = op_q;
      load_d      = load_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_error_d = res_error_q;
      acc_d       = acc_q;
      count_d     = count_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               in1_d   = cmd_operand;
               in2_d   = acc_q;
               op_d    = cmd_opcode;
               load_d  = cmd_load;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (load_q) begin
               res_data_d  = {32'b0, in1_q};
               res_error_d = 2'b00;
               acc_d       = in1_q;
            end else if (op_q[3:2] == 2'b11) begin
               // Opcodes 1100-1111 have no ALU meaning; whatever it drives is ignored.
               res_data_d  = 64'b0;
               res_error_d = 2'b11;
            end else begin
               res_data_d  = alu_output1;
               res_error_d = alu_error;
               if (alu_error == 2'b00) begin
                  acc_d = alu_output1[31:0];
               end
            end
            res_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               if (count_q != {CNT_W{1'b1}}) begin
                  count_d = count_q + 1'b1;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A fresh error outranks a simultaneous clear.
      sticky_d = sticky_q;
      if (err_clear) begin
         sticky_d = 1'b0;
      end
      if (state_q == S_ISSUE && res_error_d != 2'b00) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in1_q       <= 32'b0;
         in2_q       <= 32'b0;
         op_q        <= 4'b0;
         load_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 64'b0;
         res_error_q <= 2'b00;
         acc_q       <= 32'b0;
         sticky_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         in1_q       <= in1_d;
         in2_q       <= in2_d;
         op_q        <= op_d;
         load_q      <= load_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_error_q <= res_error_d;
         acc_q       <= acc_d;
         sticky_q    <= sticky_d;
         count_q     <= count_d;
      end
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign alu_input1 = in1_q;
   assign alu_input2 = in2_q;
   assign alu_opcode = op_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_error  = res_error_q;
   assign acc        = acc_q;
   assign err_sticky = sticky_q;
   assign op_count   = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus random commands, checked
// against a transaction-level model and a stand-in breadboard ALU.
module tb_alu_sequencer;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_load = 1'b0;
   logic [3:0]       cmd_opcode = 4'd0;
   logic [31:0]      cmd_operand = 32'd0;
   logic [31:0]      alu_input1, alu_input2;
   logic [3:0]       alu_opcode;
   logic [63:0]      alu_output1;
   logic [1:0]       alu_error;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [63:0]      res_data;
   logic [1:0]       res_error;
   logic [31:0]      acc;
   logic             err_sticky;
   logic             err_clear = 1'b0;
   logic [CNT_W-1:0] op_count;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0]      m_acc = 32'd0;
   logic [CNT_W-1:0] m_cnt = '0;
   logic             m_sticky = 1'b0;

   alu_sequencer #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand),
      .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_opcode(alu_opcode),
      .alu_output1(alu_output1), .alu_error(alu_error),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_error(res_error),
      .acc(acc), .err_sticky(err_sticky), .err_clear(err_clear),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Stand-in breadboard: returns {error, output1}. Divisor is input1.
   function automatic logic [65:0] alu_f(input logic [31:0] a1, input logic [31:0] a2,
                                         input logic [3:0] op);
      logic [63:0] o;
      logic [1:0]  e;
      e = 2'b00;
      case (op)
         4'd0: begin o = {32'b0, a2} + {32'b0, a1}; if (o[32]) e = 2'b01; end
         4'd1: begin o = {32'b0, a2} - {32'b0, a1}; if (a1 > a2) e = 2'b01; end
         4'd2: begin
            if (a1 == 0) begin o = 64'd0; e = 2'b10; end
            else o = {32'b0, a2 / a1};
         end
         4'd3:  o = {32'b0, a2} * {32'b0, a1};
         4'd4:  o = {32'b0, a2 & a1};
         4'd5:  o = {32'b0, a2 | a1};
         4'd6:  o = {32'b0, a2 ^ a1};
         4'd7:  o = {32'b0, ~(a2 & a1)};
         4'd8:  o = {32'b0, ~(a2 | a1)};
         4'd9:  o = {32'b0, a2 << a1[4:0]};
         4'd10: o = {32'b0, a2 >> a1[4:0]};
         4'd11: o = {32'b0, ~(a2 ^ a1)};
         default: begin o = 64'hDEAD_BEEF_0BAD_F00D; e = 2'b01; end
      endcase
      return {e, o};
   endfunction

   always_comb begin
      logic [65:0] r;
      r = alu_f(alu_input1, alu_input2, alu_opcode);
      alu_output1 = r[63:0];
      alu_error   = r[65:64];
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, ":cmd_ready"}, 64'(cmd_ready), 64'd1);
      check_eq({tag, ":res_valid"}, 64'(res_valid), 64'd0);
      check_eq({tag, ":res_data"}, res_data, 64'd0);
      check_eq({tag, ":res_error"}, 64'(res_error), 64'd0);
      check_eq({tag, ":acc"}, 64'(acc), 64'd0);
      check_eq({tag, ":alu_in"}, {alu_input1, alu_input2}, 64'd0);
      check_eq({tag, ":alu_op"}, 64'(alu_opcode), 64'd0);
      check_eq({tag, ":sticky"}, 64'(err_sticky), 64'd0);
      check_eq({tag, ":op_count"}, 64'(op_count), 64'd0);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after consume.
   task automatic do_cmd(input logic ld, input logic [3:0] op, input logic [31:0] opnd,
                         input int hold, input logic clr);
      logic [65:0] r;
      logic [63:0] e_data;
      logic [1:0]  e_err;
      logic [31:0] acc_before;
      acc_before = m_acc;
      if (ld) begin
         e_data = {32'b0, opnd}; e_err = 2'b00; m_acc = opnd;
      end else if (op >= 4'd12) begin
         e_data = 64'd0; e_err = 2'b11;
      end else begin
         r = alu_f(opnd, m_acc, op);
         e_data = r[63:0]; e_err = r[65:64];
         if (e_err == 2'b00) m_acc = r[31:0];
      end
      if (e_err != 2'b00) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;

      check_eq("idle:cmd_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_load = ld; cmd_opcode = op; cmd_operand = opnd;
      @(negedge clk);
      check_eq("issue:cmd_ready", 64'(cmd_ready), 64'd0);
      check_eq("issue:res_valid", 64'(res_valid), 64'd0);
      check_eq("issue:alu_input1", 64'(alu_input1), 64'(opnd));
      check_eq("issue:alu_input2", 64'(alu_input2), 64'(acc_before));
      check_eq("issue:alu_opcode", 64'(alu_opcode), 64'(op));
      cmd_valid = 1'b0;
      cmd_operand = $urandom;
      err_clear = clr;
      res_ready = (hold == 0);
      @(negedge clk);
      err_clear = 1'b0;
      check_eq("resp:res_valid", 64'(res_valid), 64'd1);
      check_eq("resp:res_data", res_data, e_data);
      check_eq("resp:res_error", 64'(res_error), 64'(e_err));
      check_eq("resp:acc", 64'(acc), 64'(m_acc));
      check_eq("resp:sticky", 64'(err_sticky), 64'(m_sticky));
      check_eq("resp:cmd_ready", 64'(cmd_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("hold:res_valid", 64'(res_valid), 64'd1);
         check_eq("hold:res_data", res_data, e_data);
         check_eq("hold:res_error", 64'(res_error), 64'(e_err));
         check_eq("hold:cmd_ready", 64'(cmd_ready), 64'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      check_eq("done:res_valid", 64'(res_valid), 64'd0);
      check_eq("done:cmd_ready", 64'(cmd_ready), 64'd1);
      check_eq("done:op_count", 64'(op_count), 64'(m_cnt));
      $display("cmd load=%0d op=%h operand=%h -> data=%h err=%b acc=%h cnt=%0d",
               ld, op, opnd, res_data, res_error, acc, op_count);
   endtask

   initial begin
      logic [31:0] opnd;
      logic [3:0]  op;
      #1;
      check_reset_state("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed scenarios
      do_cmd(1'b1, 4'd0, 32'd7, 0, 1'b0);
      do_cmd(1'b0, 4'd0, 32'd5, 0, 1'b0);
      check_eq("t2:op_count", 64'(op_count), 64'd2);
      do_cmd(1'b0, 4'd2, 32'd0, 0, 1'b0);
      check_eq("t3:acc", 64'(acc), 64'd12);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      m_sticky = 1'b0;
      check_eq("t3:sticky_clr", 64'(err_sticky), 64'd0);
      do_cmd(1'b0, 4'd13, 32'd3, 5, 1'b0);
      do_cmd(1'b0, 4'd2, 32'd0, 0, 1'b1);
      check_eq("setwins:sticky", 64'(err_sticky), 64'd1);
      do_cmd(1'b1, 4'd0, 32'h6D, 1, 1'b0);
      do_cmd(1'b0, 4'd4, 32'hDB, 0, 1'b0);
      check_eq("t5:acc", 64'(acc), 64'h49);

      // Random traffic; also drives op_count into saturation
      for (int n = 0; n < 40; n++) begin
         op = 4'($urandom_range(0, 15));
         opnd = $urandom;
         if ($urandom_range(0, 3) == 0) opnd = 32'($urandom_range(0, 3));
         do_cmd(($urandom_range(0, 9) < 3), op, opnd, $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0));
      end
      check_eq("sat:op_count", 64'(op_count), 64'hF);

      // Asynchronous reset while a result is pending
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 32'h1234_5678;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check_eq("t6:res_valid_pre", 64'(res_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_state("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      m_acc = 32'd0; m_cnt = '0; m_sticky = 1'b0;
      @(negedge clk);
      do_cmd(1'b0, 4'd0, 32'd9, 0, 1'b0);
      check_eq("post:acc", 64'(acc), 64'd9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Registered command sequencer that sits directly upstream of the `breadboard` ALU and also consumes its result. It owns a 32-bit accumulator and accepts one command at a time over a valid/ready handshake. For each command it drives the ALU's `input1`, `input2` and `opcode` from registers and captures the combinational `output1`/`error` one cycle later. It returns the result over a second valid/ready handshake and writes the low word back into the accumulator when the operation is error-free.

## Interface
Parameters:
- `CNT_W`, default 16: width of the completed-operation counter.

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_load` input 1: 1 = load accumulator with `cmd_operand`, no ALU operation.
- `cmd_opcode` input 4: ALU opcode (0000 add … 1011 XNOR).
- `cmd_operand` input 32: second operand.
- `alu_input1` output 32: to breadboard `input1`; carries `cmd_operand`.
- `alu_input2` output 32: to breadboard `input2`; carries the accumulator.
- `alu_opcode` output 4: to breadboard `opcode`.
- `alu_output1` input 64: from breadboard `output1`.
- `alu_error` input 2: from breadboard `error`.
- `res_valid` output 1: result present.
- `res_ready` input 1: consumer accepts result.
- `res_data` output 64: captured result.
- `res_error` output 2: captured error code.
- `acc` output 32: current accumulator value.
- `err_sticky` output 1: set on any nonzero `res_error`, cleared by `err_clear`.
- `err_clear` input 1: clears `err_sticky`.
- `op_count` output CNT_W: completed responses, saturating.

## Operation
- States: IDLE, ISSUE, RESP.
- `cmd_ready` = (state == IDLE).

IDLE:
- On `cmd_valid & cmd_ready` at an edge:
  - register `alu_input1` <= `cmd_operand`;
  - register `alu_input2` <= `acc`;
  - register `alu_opcode` <= `cmd_opcode`;
  - latch `cmd_load` internally.
- Next state is ISSUE.

ISSUE (exactly one cycle; the ALU is combinational and settles within it):
- Load command: `res_data` <= {32'b0, `alu_input1`}, `res_error` <= 2'b00, `acc` <= `alu_input1`.
- Illegal opcode 1100–1111: `res_data` <= 64'b0, `res_error` <= 2'b11, `acc` unchanged; the ALU output is ignored.
- Otherwise: `res_data` <= `alu_output1`, `res_error` <= `alu_error`.
  - `acc` <= `alu_output1[31:0]` only if `alu_error` == 2'b00; otherwise `acc` is unchanged.
- In all cases `res_valid` <= 1 and the next state is RESP.

RESP:
- `res_valid`, `res_data` and `res_error` are held stable until `res_valid & res_ready` at an edge.
- At that edge: `res_valid` <= 0, `op_count` increments (saturates at all-ones), next state is IDLE.

Error tracking:
- `err_sticky` is set on the ISSUE→RESP edge whenever the captured `res_error` is nonzero.
- `err_clear` clears `err_sticky`. If set and clear occur on the same edge, set wins.

ALU outputs:
- `alu_*` outputs hold their last value outside ISSUE; they are never driven combinationally from `cmd_*`.

## Timing
- Reset values: state IDLE, `cmd_ready` 1, `res_valid` 0, `res_data` 0, `res_error` 00, `acc` 0, `alu_input1` 0, `alu_input2` 0, `alu_opcode` 0000, `err_sticky` 0, `op_count` 0.
- Latency: command accepted at edge N → `res_valid` high after edge N+1. With `res_ready` held at 1, the result is consumed at edge N+2 and the next command can be accepted at edge N+3. Minimum issue interval is 3 cycles.
- `cmd_ready` is low in ISSUE and RESP. `cmd_valid` arriving in those states is not accepted and must be held by the sender.
- Backpressure: `res_ready` low holds RESP indefinitely with all outputs stable. `acc` has already been updated at that point.
- `rst_n` asserted mid-operation (ISSUE or RESP) returns all state to reset values immediately. The in-flight result is discarded and `op_count` is not incremented.
- The accumulator update is visible on `acc` in the same cycle `res_valid` rises. A command accepted immediately after therefore uses the new value.

## Test plan
1. Reset, then load 32'd7 → `res_data`=64'd7, `res_error`=00, `acc`=7; `res_valid` rises one cycle after accept.
2. `acc`=7, add opcode 0000 with operand 5 → `res_data`=64'd12, `acc`=12, `op_count`=2.
3. `acc`=12, divide opcode 0010 with operand 0 → `res_error`=10, `acc` stays 12, `err_sticky`=1. Then pulse `err_clear` → `err_sticky`=0.
4. Opcode 1101 with operand 3 → `res_error`=11, `res_data`=0, `acc` unchanged. Hold `res_ready`=0 for 5 cycles → `res_valid` and data stable, `cmd_ready`=0 throughout.
5. `acc`=8'b01101101 (load 32'h6D), AND opcode 0100 with operand 32'hDB → `res_data`=64'h49, `acc`=32'h49.
6. Assert `rst_n`=0 while in RESP → `res_valid`=0, `acc`=0, `op_count`=0, `cmd_ready`=1 immediately, with no clock edge required.
